// File: rtl/dmem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_port_arbiter_if
//  Description : Requester-side bus of the data-memory port arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface dmem_port_arbiter_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req, we, addr, wdata, wmask,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata, wmask,
        output gnt, rvalid, rdata
    );
endinterface
`default_nettype wire

// File: rtl/dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_port_arbiter
//  Description : Two-requester arbiter for memory_2rw port 0 with m0 priority
//                and a starvation counter guaranteeing m1 forward progress.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_port_arbiter #(
    parameter int ADDR_WIDTH   = 11,
    parameter int STARVE_LIMIT = 4
) (
    input  wire logic                  clk_i,
    input  wire logic                  reset_i,
    dmem_port_arbiter_if.slave         m0,
    dmem_port_arbiter_if.slave         m1,
    output logic                       mem_csb_o,
    output logic                       mem_web_o,
    output logic [3:0]                 mem_wmask_o,
    output logic [ADDR_WIDTH-1:0]      mem_addr_o,
    output logic [31:0]                mem_din_o,
    input  wire logic [31:0]           mem_dout_i
);

    localparam int                 CW          = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0]      c_LIMIT     = CW'(STARVE_LIMIT);
    localparam logic [CW-1:0]      c_ONE       = CW'(1);
    localparam logic [0:0]         c_ST_NORMAL = 1'b0;
    localparam logic [0:0]         c_ST_FORCED = 1'b1;

    logic [CW-1:0] starve_cnt_q, starve_cnt_d;
    logic          resp_valid_q;
    logic          resp_owner_q;
    logic [0:0]    w_state;
    logic          w_gnt0;
    logic          w_gnt1;

    // The saturated counter value is the FORCED state; everything below is NORMAL.
    assign w_state = (starve_cnt_q == c_LIMIT) ? c_ST_FORCED : c_ST_NORMAL;

    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (!reset_i) begin
            if ((w_state == c_ST_FORCED) && m1.req) begin
                w_gnt1 = 1'b1;
            end else if (m0.req) begin
                w_gnt0 = 1'b1;
            end else if (m1.req) begin
                w_gnt1 = 1'b1;
            end
        end
    end

    assign m0.gnt = w_gnt0;
    assign m1.gnt = w_gnt1;

    always_comb begin
        mem_csb_o   = 1'b1;
        mem_web_o   = 1'b1;
        mem_wmask_o = 4'h0;
        mem_addr_o  = '0;
        mem_din_o   = 32'h0;
        if (w_gnt0) begin
            mem_csb_o   = 1'b0;
            mem_web_o   = ~m0.we;
            mem_wmask_o = m0.wmask;
            mem_addr_o  = m0.addr[ADDR_WIDTH+1:2];
            mem_din_o   = m0.wdata;
        end else if (w_gnt1) begin
            mem_csb_o   = 1'b0;
            mem_web_o   = ~m1.we;
            mem_wmask_o = m1.wmask;
            mem_addr_o  = m1.addr[ADDR_WIDTH+1:2];
            mem_din_o   = m1.wdata;
        end
    end

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!m1.req || w_gnt1) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q != c_LIMIT) begin
            starve_cnt_d = starve_cnt_q + c_ONE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            starve_cnt_q <= '0;
            resp_valid_q <= 1'b0;
            resp_owner_q <= 1'b0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            resp_valid_q <= w_gnt0 | w_gnt1;
            resp_owner_q <= w_gnt1;
        end
    end

    // Masking with reset_i drops a response whose access was granted just before reset.
    assign m0.rvalid = resp_valid_q & ~resp_owner_q & ~reset_i;
    assign m1.rvalid = resp_valid_q &  resp_owner_q & ~reset_i;
    assign m0.rdata  = m0.rvalid ? mem_dout_i : 32'h0;
    assign m1.rdata  = m1.rvalid ? mem_dout_i : 32'h0;

    logic w_unused_addr_bits;
    assign w_unused_addr_bits = ^{m0.addr[31:ADDR_WIDTH+2], m0.addr[1:0],
                                  m1.addr[31:ADDR_WIDTH+2], m1.addr[1:0]};

endmodule
`default_nettype wire
